recip_serial_host: RTL and testbench

Parallel-to-serial host stage that sits directly upstream of the nibble-serial reciprocal core and drives its 8-bit pin interface. It accepts Q6.10 operands over a valid/ready handshake and shifts each one into the core as four nibbles, MSB first. It samples the two result bytes the core returns, reassembles the Q6.10 reciprocal, and presents it over a second valid/ready handshake. It runs in lock-step with the core's fixed 6-cycle frame.

---
 rtl/recip_serial_host.sv | 189 ++++++++++++++++++
 tb/tb_recip_serial_host.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/recip_serial_host.sv
// recip_serial_host
// Parallel-to-serial host stage for the nibble-serial reciprocal core.
// Accepts Q6.10 operands over valid/ready and shifts each one into the core
// as four nibbles, MSB first. It then collects the two returned bytes and
// presents the Q6.10 reciprocal over a second valid/ready handshake. The host
// runs in lock-step with the core's fixed 6-cycle frame.
//
// Build option:
//   RECIP_HOST_OBUF2_EN  defined   -> 2-entry output FIFO
//                        undefined -> single output register (default)

module recip_serial_host (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    input  logic        in_abs,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic        ser_rst,
    output logic        ser_abs,
    output logic [3:0]  ser_nib,
    input  logic [7:0]  ser_byte,
    output logic        busy
);

    typedef enum logic [2:0] {
        PH0 = 3'd0,
        PH1 = 3'd1,
        PH2 = 3'd2,
        PH3 = 3'd3,
        PH4 = 3'd4,
        PH5 = 3'd5
    } phase_t;

    phase_t      phase;
    phase_t      phase_next;
    logic        accept;
    logic        job_q;
    logic        abs_q;
    // The top nibble goes to the core combinationally at acceptance, so only
    // the lower three nibbles need to be held.
    logic [11:0] opreg;
    logic [7:0]  lowbyte;
    logic        obuf_full;
    logic        push;
    logic        pop;

    // The core shares the host reset so both step counters restart together.
    assign ser_rst = reset;
    assign busy    = job_q && (phase != PH0);
    assign push    = (phase == PH5) && job_q;
    assign pop     = out_valid && out_ready;

    // Free-running frame phase register, forced to phase 0 by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            phase <= PH0;
        end else begin
            phase <= phase_next;
        end
    end

    // Frame sequencing plus the per-phase nibble/abs drive toward the core.
    always_comb begin
        phase_next = PH0;
        in_ready   = 1'b0;
        accept     = 1'b0;
        ser_nib    = 4'h0;
        ser_abs    = 1'b0;
        case (phase)
            PH0: begin
                phase_next = PH1;
                in_ready   = (!obuf_full || out_ready) && !reset;
                accept     = in_valid && in_ready;
                if (accept) begin
                    ser_nib = in_data[15:12];
                    ser_abs = in_abs;
                end
            end
            PH1: begin
                phase_next = PH2;
                ser_nib    = job_q ? opreg[11:8] : 4'h0;
                ser_abs    = job_q && abs_q;
            end
            PH2: begin
                phase_next = PH3;
                ser_nib    = job_q ? opreg[7:4] : 4'h0;
                ser_abs    = job_q && abs_q;
            end
            PH3: begin
                phase_next = PH4;
                ser_nib    = job_q ? opreg[3:0] : 4'h0;
                ser_abs    = job_q && abs_q;
            end
            PH4: begin
                phase_next = PH5;
                ser_abs    = job_q && abs_q;
            end
            PH5: begin
                phase_next = PH0;
                ser_abs    = job_q && abs_q;
            end
            default: begin
                phase_next = PH0;
            end
        endcase
    end

    // Job flag, abs bit and operand are latched at the phase-0 edge; an
    // unaccepted phase 0 turns the frame idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            job_q <= 1'b0;
            abs_q <= 1'b0;
            opreg <= 12'h000;
        end else if (phase == PH0) begin
            job_q <= accept;
            if (accept) begin
                abs_q <= in_abs;
                opreg <= in_data[11:0];
            end
        end
    end

    // Low result byte is returned by the core during phase 4.
    always_ff @(posedge clk) begin
        if (reset) begin
            lowbyte <= 8'h00;
        end else if ((phase == PH4) && job_q) begin
            lowbyte <= ser_byte;
        end
    end

`ifdef RECIP_HOST_OBUF2_EN
    logic [15:0] obuf_mem [2];
    logic        rd_ptr;
    logic        wr_ptr;
    logic [1:0]  count;

    assign obuf_full = (count == 2'd2);
    assign out_valid = (count != 2'd0);
    assign out_data  = obuf_mem[rd_ptr];

    // Two-entry FIFO; a push can only land at phase 5 and acceptance already
    // guaranteed room for it, so no overflow guard is needed.
    always_ff @(posedge clk) begin
        if (reset) begin
            obuf_mem[0] <= 16'h0000;
            obuf_mem[1] <= 16'h0000;
            rd_ptr      <= 1'b0;
            wr_ptr      <= 1'b0;
            count       <= 2'd0;
        end else begin
            if (push) begin
                obuf_mem[wr_ptr] <= {ser_byte, lowbyte};
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end
`else
    logic [15:0] data_q;
    logic        valid_q;

    assign obuf_full = valid_q;
    assign out_valid = valid_q;
    assign out_data  = data_q;

    // Single result register; a push overrides a same-edge pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q  <= 16'h0000;
            valid_q <= 1'b0;
        end else if (push) begin
            data_q  <= {ser_byte, lowbyte};
            valid_q <= 1'b1;
        end else if (pop) begin
            valid_q <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_recip_serial_host.sv
// tb_recip_serial_host
// Scoreboard bench for recip_serial_host with a behavioural nibble-serial
// reciprocal core attached to the ser_* pins. Honours RECIP_HOST_OBUF2_EN.

module tb_recip_serial_host;

`ifdef RECIP_HOST_OBUF2_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        in_abs;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        ser_rst;
    logic        ser_abs;
    logic [3:0]  ser_nib;
    logic [7:0]  ser_byte;
    logic        busy;

    int checks = 0;
    int errors = 0;

    // Reference model state: frame phase, the job in flight, buffer contents.
    bit          started = 1'b0;
    int          mphase = 0;
    bit          inflight = 1'b0;
    logic [15:0] inflight_val = 16'h0;
    logic [15:0] inflight_op = 16'h0;
    bit          inflight_abs = 1'b0;
    logic [15:0] exp_q[$];

    bit rnd_ready = 1'b0;
    bit core_force = 1'b0;

    always #5 clk = ~clk;

    recip_serial_host dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_abs    (in_abs),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .ser_rst   (ser_rst),
        .ser_abs   (ser_abs),
        .ser_nib   (ser_nib),
        .ser_byte  (ser_byte),
        .busy      (busy)
    );

    // Saturating Q6.10 reciprocal, with the optional abs applied to the result.
    function automatic logic [15:0] recip_ref(input logic [15:0] x, input logic a);
        int v;
        int mag;
        int q;
        int r;
        v = $signed(x);
        if (v == 0) begin
            r = 32767;
        end else begin
            mag = (v < 0) ? -v : v;
            q = (1 << 20) / mag;
            if (v > 0) r = (q > 32767) ? 32767 : q;
            else       r = (q > 32768) ? -32768 : -q;
        end
        if (a && (r < 0)) r = (r == -32768) ? 32767 : -r;
        return r[15:0];
    endfunction

    // Behavioural core: collects four nibbles, returns low then high byte.
    logic [2:0]  core_step;
    logic [11:0] core_acc;
    logic [15:0] core_op;
    logic [15:0] core_res;

    always @(posedge clk) begin
        if (ser_rst) begin
            core_step <= 3'd0;
            core_acc  <= 12'h0;
            core_op   <= 16'h0;
        end else begin
            core_step <= (core_step == 3'd5) ? 3'd0 : core_step + 3'd1;
            if (core_step <= 3'd2) core_acc <= {core_acc[7:0], ser_nib};
            if (core_step == 3'd3) core_op <= {core_acc, ser_nib};
        end
    end

    assign core_res = core_force ? 16'hC35A : recip_ref(core_op, ser_abs);
    assign ser_byte = (core_step == 3'd4) ? core_res[7:0] :
                      (core_step == 3'd5) ? core_res[15:8] : 8'hEE;

    task automatic checkOutput(input string name, input logic [15:0] actual,
                               input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%04h expected 0x%04h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    function automatic bit expInReady();
        return !reset && (mphase == 0) && ((exp_q.size() < DEPTH) || out_ready);
    endfunction

    function automatic logic [3:0] expNib();
        case (mphase)
            0: return (in_valid && expInReady()) ? in_data[15:12] : 4'h0;
            1: return inflight ? inflight_op[11:8] : 4'h0;
            2: return inflight ? inflight_op[7:4] : 4'h0;
            3: return inflight ? inflight_op[3:0] : 4'h0;
            default: return 4'h0;
        endcase
    endfunction

    function automatic logic expAbs();
        if (mphase == 0) return in_valid && expInReady() && in_abs;
        return inflight && inflight_abs;
    endfunction

    // Monitor and model update at each active edge: pop and compare on an
    // output handshake, move a finished job into the expected buffer, and
    // record a newly accepted operand.
    initial begin
        forever begin
            @(posedge clk);
            if (started) begin
                if (reset) begin
                    mphase   = 0;
                    inflight = 1'b0;
                    exp_q.delete();
                end else begin
                    bit acc_now;
                    acc_now = (mphase == 0) && in_valid && expInReady();
                    if (out_valid && out_ready) begin
                        if (exp_q.size() == 0) begin
                            checkOutput("pop_unexpected", 16'(out_valid), 16'd0);
                        end else begin
                            checkOutput("pop_data", out_data, exp_q.pop_front());
                        end
                    end
                    if ((mphase == 5) && inflight) begin
                        exp_q.push_back(inflight_val);
                        inflight = 1'b0;
                    end
                    if (mphase == 0) begin
                        inflight = 1'b0;
                        if (acc_now) begin
                            inflight     = 1'b1;
                            inflight_op  = in_data;
                            inflight_abs = in_abs;
                            inflight_val = core_force ? 16'hC35A : recip_ref(in_data, in_abs);
                        end
                    end
                    mphase = (mphase == 5) ? 0 : mphase + 1;
                end
            end
        end
    end

    // Per-cycle pin checks against the model, well away from the edge.
    initial begin
        forever begin
            @(negedge clk);
            #4;
            if (started) begin
                checkOutput("in_ready", 16'(in_ready), 16'(expInReady()));
                checkOutput("out_valid", 16'(out_valid), 16'(exp_q.size() > 0));
                if (exp_q.size() > 0) checkOutput("out_data", out_data, exp_q[0]);
                checkOutput("busy", 16'(busy), 16'(inflight && (mphase != 0)));
                checkOutput("ser_rst", 16'(ser_rst), 16'(reset));
                checkOutput("ser_nib", 16'(ser_nib), 16'(expNib()));
                checkOutput("ser_abs", 16'(ser_abs), 16'(expAbs()));
            end
        end
    end

    // Random out_ready when enabled.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #500000;
        errors++;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic waitPhase(input int p);
        int n;
        n = 0;
        while ((mphase != p) && (n < 12)) begin
            tick();
            n++;
        end
        if (mphase != p) checkOutput("phase_wait", 16'(mphase), 16'(p));
    endtask

    task automatic waitOutValid();
        for (int i = 0; i < 15; i++) begin
            if (out_valid) break;
            tick();
        end
        checkOutput("out_valid_wait", 16'(out_valid), 16'd1);
    endtask

    task automatic applyStimulus(input logic [15:0] d, input logic a);
        bit accepted;
        accepted = 1'b0;
        in_data  = d;
        in_abs   = a;
        in_valid = 1'b1;
        for (int i = 0; i < 80; i++) begin
            #1;
            if (in_ready) accepted = 1'b1;
            tick();
            if (accepted) break;
        end
        in_valid = 1'b0;
        checkOutput("accept", 16'(accepted), 16'd1);
    endtask

    initial begin
        int lat;
        logic [15:0] d;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = 16'h0;
        in_abs    = 1'b0;
        out_ready = 1'b1;

        repeat (2) @(posedge clk);
        tick();
        started = 1'b1;
        #2;
        checkOutput("rst_in_ready", 16'(in_ready), 16'd0);
        checkOutput("rst_out_valid", 16'(out_valid), 16'd0);
        checkOutput("rst_busy", 16'(busy), 16'd0);
        checkOutput("rst_ser_nib", 16'(ser_nib), 16'd0);
        checkOutput("rst_ser_abs", 16'(ser_abs), 16'd0);
        checkOutput("rst_out_data", out_data, 16'h0000);
        tick();
        reset = 1'b0;

        $display("[TB] single job 1.0");
        waitPhase(0);
        in_data = 16'h0400; in_abs = 1'b0; in_valid = 1'b1;
        #1;
        checkOutput("t1_in_ready", 16'(in_ready), 16'd1);
        checkOutput("t1_nib0", 16'(ser_nib), 16'h0);
        tick();
        in_valid = 1'b0;
        #1 checkOutput("t1_nib1", 16'(ser_nib), 16'h4);
        tick();
        #1 checkOutput("t1_nib2", 16'(ser_nib), 16'h0);
        tick();
        #1 checkOutput("t1_nib3", 16'(ser_nib), 16'h0);
        lat = 3;
        while (!out_valid && (lat < 20)) begin
            tick();
            lat++;
        end
        checkOutput("t1_latency", 16'(lat), 16'd6);
        checkOutput("t1_out_data", out_data, 16'h0400);

        $display("[TB] byte assembly");
        waitPhase(0);
        core_force = 1'b1;
        applyStimulus(16'h1234, 1'b0);
        waitOutValid();
        checkOutput("t2_bytes", out_data, 16'hC35A);
        tick();
        core_force = 1'b0;

        $display("[TB] abs hold");
        waitPhase(0);
        in_data = 16'hFC00; in_abs = 1'b1; in_valid = 1'b1;
        #1 checkOutput("t3_abs_ph0", 16'(ser_abs), 16'd1);
        for (int i = 1; i <= 5; i++) begin
            tick();
            in_valid = 1'b0;
            #1 checkOutput("t3_abs_hold", 16'(ser_abs), 16'd1);
        end
        tick();
        waitOutValid();
        checkOutput("t3_result", out_data, 16'h0400);

        $display("[TB] reset mid-frame");
        waitPhase(0);
        in_data = 16'h0200; in_abs = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        #1 checkOutput("t4_ser_rst", 16'(ser_rst), 16'd1);
        tick();
        #1;
        checkOutput("t4_busy", 16'(busy), 16'd0);
        checkOutput("t4_out_valid", 16'(out_valid), 16'd0);
        checkOutput("t4_ser_nib", 16'(ser_nib), 16'd0);
        reset = 1'b0;
        #1 checkOutput("t4_phase0_ready", 16'(in_ready), 16'd1);
        for (int i = 0; i < 12; i++) begin
            tick();
            checkOutput("t4_no_result", 16'(out_valid), 16'd0);
        end

        $display("[TB] backpressure");
        waitPhase(0);
        out_ready = 1'b0;
        applyStimulus(16'h0800, 1'b0);
        in_data = 16'h0100; in_abs = 1'b0; in_valid = 1'b1;
        waitPhase(0);
        #1;
        checkOutput("t5_held_first", out_data, 16'h0200);
`ifdef RECIP_HOST_OBUF2_EN
        checkOutput("t5_second_ready", 16'(in_ready), 16'd1);
        tick();
        in_data = 16'h2000; in_valid = 1'b1;
        waitPhase(0);
        #1;
        checkOutput("t5_third_blocked", 16'(in_ready), 16'd0);
        checkOutput("t5_head_stable", out_data, 16'h0200);
`else
        checkOutput("t5_second_blocked", 16'(in_ready), 16'd0);
`endif
        repeat (12) tick();
        waitPhase(0);
        out_ready = 1'b1;
        #1 checkOutput("t5_unblocked", 16'(in_ready), 16'd1);
        tick();
        in_valid = 1'b0;
        repeat (20) tick();

        $display("[TB] random traffic");
        rnd_ready = 1'b1;
        for (int j = 0; j < 40; j++) begin
            repeat ($urandom_range(0, 8)) tick();
            case ($urandom_range(0, 7))
                0: d = 16'h0000;
                1: d = 16'h8000;
                2: d = 16'h0001;
                default: d = 16'($urandom);
            endcase
            applyStimulus(d, 1'($urandom_range(0, 1)));
        end
        rnd_ready = 1'b0;
        tick();
        out_ready = 1'b1;
        repeat (30) tick();
        checkOutput("drain_empty", 16'(exp_q.size()), 16'd0);
        checkOutput("drain_out_valid", 16'(out_valid), 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
